// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetcher_pkg;

  // Machine word width; PCs and instruction slots are this wide.
  localparam int XLEN = 32;

  // Default log2 of the I-cache entry count (64 entries of one instruction each).
  localparam int ICACHE_IDX_W_DEF = 6;

  // PC the fetcher starts from after reset.
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // FETCH looks up the cache; WAIT parks until the matching refill shows up.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } fetch_state_e;

  // A compressed instruction is anything whose two low opcode bits are not 2'b11.
  function automatic logic is_rvc(input logic [XLEN-1:0] inst);
    return (inst[1:0] != 2'b11);
  endfunction

  // Sequential successor PC; wraps silently at the top of the address space.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc, input logic rvc);
    logic [XLEN-1:0] nxt;
    if (rvc) begin
      nxt = pc + 32'd2;
    end else begin
      nxt = pc + 32'd4;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Bus bundle between the fetch stage, the ROB/decoder side and memory_controller.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  // global enable
  logic            rdy;
  // redirect from the ROB
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  // decoder back-pressure
  logic            stall;
  // memory_controller refill side
  logic            mem_fet_busy;
  logic            mem_inst_ready;
  logic [XLEN-1:0] mem_inst;
  logic [XLEN-1:0] mem_inst_addr;
  // fetch request to memory_controller
  logic            fet_mem_enable;
  logic [XLEN-1:0] fet_pc;
  // issued instruction to the decoder
  logic            fet_inst_valid;
  logic [XLEN-1:0] fet_inst;
  logic [XLEN-1:0] fet_inst_pc;
  logic            fet_inst_is_c;

  // The fetch stage itself.
  modport master (
    input  rdy, flush, flush_pc, stall,
    input  mem_fet_busy, mem_inst_ready, mem_inst, mem_inst_addr,
    output fet_mem_enable, fet_pc,
    output fet_inst_valid, fet_inst, fet_inst_pc, fet_inst_is_c
  );

  // Everything around it: ROB, decoder and memory_controller.
  modport slave (
    output rdy, flush, flush_pc, stall,
    output mem_fet_busy, mem_inst_ready, mem_inst, mem_inst_addr,
    input  fet_mem_enable, fet_pc,
    input  fet_inst_valid, fet_inst, fet_inst_pc, fet_inst_is_c
  );

endinterface

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped instruction cache: one instruction per entry, combinational
// read port, synchronous write port, valid bits cleared by reset.
module inst_fetcher_icache_dm
  import inst_fetcher_pkg::*;
#(
  parameter int IDX_W = inst_fetcher_pkg::ICACHE_IDX_W_DEF,
  parameter int TAG_W = inst_fetcher_pkg::XLEN - IDX_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [XLEN-1:0]  rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_data
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r  [ENTRIES];
  logic [XLEN-1:0]    data_r [ENTRIES];

  // Valid bits: wiped on reset, set by each refill write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: plain storage, only meaningful where valid is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

  // Lookup: hit when the indexed entry is valid and its tag matches.
  always_comb begin
    rd_hit  = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    rd_data = data_r[rd_idx];
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: holds the PC, looks it up in the direct-mapped
// I-cache, requests misses from memory_controller and issues one instruction
// per cycle to the decoder. Prediction is purely sequential.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int              ICACHE_IDX_W = inst_fetcher_pkg::ICACHE_IDX_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC     = inst_fetcher_pkg::RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetcher_if.master bus
);

  localparam int TAG_W = XLEN - ICACHE_IDX_W - 1;

  // architectural fetch state
  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;

  // registered outputs and their next values
  logic            mem_en_r;
  logic            mem_en_nxt_s;
  logic [XLEN-1:0] fet_pc_r;
  logic [XLEN-1:0] fet_pc_nxt_s;
  logic            inst_valid_r;
  logic            inst_valid_nxt_s;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] inst_nxt_s;
  logic [XLEN-1:0] inst_pc_r;
  logic [XLEN-1:0] inst_pc_nxt_s;
  logic            inst_is_c_r;
  logic            inst_is_c_nxt_s;

  // cache interface
  logic              hit_s;
  logic [XLEN-1:0]   rd_data_s;
  logic              rvc_s;
  logic              refill_match_s;
  logic              cache_wr_s;
  logic [ICACHE_IDX_W-1:0] pc_idx_s;
  logic [TAG_W-1:0]  pc_tag_s;
  logic [ICACHE_IDX_W-1:0] refill_idx_s;
  logic [TAG_W-1:0]  refill_tag_s;

  assign pc_idx_s     = pc_r[ICACHE_IDX_W:1];
  assign pc_tag_s     = pc_r[XLEN-1:ICACHE_IDX_W+1];
  assign refill_idx_s = bus.mem_inst_addr[ICACHE_IDX_W:1];
  assign refill_tag_s = bus.mem_inst_addr[XLEN-1:ICACHE_IDX_W+1];
  assign rvc_s        = is_rvc(rd_data_s);

  // Refill acceptance: only while waiting, and only for the PC we are parked
  // on. Stale refills from a fetch that a flush abandoned fail the address
  // check. A refill landing in the same cycle as a flush is still written.
  always_comb begin
    refill_match_s = (state_r == ST_WAIT) && bus.mem_inst_ready &&
                     (bus.mem_inst_addr == pc_r);
    cache_wr_s     = bus.rdy && !rst && refill_match_s;
  end

  inst_fetcher_icache_dm #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_idx_s),
    .rd_tag  (pc_tag_s),
    .rd_hit  (hit_s),
    .rd_data (rd_data_s),
    .wr_en   (cache_wr_s),
    .wr_idx  (refill_idx_s),
    .wr_tag  (refill_tag_s),
    .wr_data (bus.mem_inst)
  );

  // Next-state and next-output logic; flush outranks normal operation.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    mem_en_nxt_s     = 1'b0;
    fet_pc_nxt_s     = fet_pc_r;
    inst_valid_nxt_s = inst_valid_r;
    inst_nxt_s       = inst_r;
    inst_pc_nxt_s    = inst_pc_r;
    inst_is_c_nxt_s  = inst_is_c_r;

    if (bus.flush) begin
      pc_nxt_s         = bus.flush_pc;
      state_nxt_s      = ST_FETCH;
      inst_valid_nxt_s = 1'b0;
      mem_en_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (hit_s) begin
            if (!bus.stall) begin
              inst_valid_nxt_s = 1'b1;
              inst_nxt_s       = rd_data_s;
              inst_pc_nxt_s    = pc_r;
              inst_is_c_nxt_s  = rvc_s;
              pc_nxt_s         = pc_step(pc_r, rvc_s);
            end else begin
              // decoder is full: the issued instruction and the PC stay put
              inst_valid_nxt_s = inst_valid_r;
            end
          end else begin
            if (!bus.stall) begin
              inst_valid_nxt_s = 1'b0;
            end else begin
              inst_valid_nxt_s = inst_valid_r;
            end
            if (!bus.mem_fet_busy) begin
              mem_en_nxt_s = 1'b1;
              fet_pc_nxt_s = pc_r;
              state_nxt_s  = ST_WAIT;
            end else begin
              // controller occupied: retry the lookup next cycle
              mem_en_nxt_s = 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.stall) begin
            inst_valid_nxt_s = 1'b0;
          end else begin
            inst_valid_nxt_s = inst_valid_r;
          end
          if (refill_match_s) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        default: begin
          state_nxt_s = ST_FETCH;
        end
      endcase
    end
  end

  // State and output registers; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      mem_en_r     <= 1'b0;
      fet_pc_r     <= '0;
      inst_valid_r <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= '0;
      inst_is_c_r  <= 1'b0;
    end else if (bus.rdy) begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      mem_en_r     <= mem_en_nxt_s;
      fet_pc_r     <= fet_pc_nxt_s;
      inst_valid_r <= inst_valid_nxt_s;
      inst_r       <= inst_nxt_s;
      inst_pc_r    <= inst_pc_nxt_s;
      inst_is_c_r  <= inst_is_c_nxt_s;
    end
  end

  assign bus.fet_mem_enable = mem_en_r;
  assign bus.fet_pc         = fet_pc_r;
  assign bus.fet_inst_valid = inst_valid_r;
  assign bus.fet_inst       = inst_r;
  assign bus.fet_inst_pc    = inst_pc_r;
  assign bus.fet_inst_is_c  = inst_is_c_r;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: a behavioural memory model answers fetch
// requests, stimulus pushes redirects into a queue, and a monitor walks the
// expected program-order stream and checks every issued instruction.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  logic clk = 1'b0;
  logic rst;
  inst_fetcher_if bus();

  inst_fetcher dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard / reference state
  logic [31:0] redir_q[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] fetch_exp_prev = 32'h0;
  logic [31:0] mon_ei;
  bit          mon_pend;
  bit          men_prev = 1'b0;
  bit          busy_prev = 1'b0;
  bit          flush_prev = 1'b0;
  bit          mon_on = 1'b0;
  int          consumed = 0;
  int          idle_cyc = 0;

  // memory-side knobs
  bit          force_busy = 1'b0;
  bit          rand_busy  = 1'b0;
  bit          junk_en    = 1'b0;
  logic [31:0] rq_addr[$];
  int          rq_dly[$];

  // Program image: a fixed pseudo-random halfword per address, with the first
  // few words pinned to known instructions.
  function automatic logic [15:0] img_hw(input logic [31:0] a);
    logic [31:0] h;
    logic [15:0] r;
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 13);
    h = h * 32'h85EB_CA6B;
    r = h[31:16];
    case (a)
      32'h0:   r = 16'h0013;
      32'h2:   r = 16'h0000;
      32'h4:   r = 16'h4501;
      32'h6:   r = 16'h0001;
      default: r = r;
    endcase
    return r;
  endfunction

  // Instruction at an address: 16-bit zero-extended, or 32-bit spanning two halfwords.
  function automatic logic [31:0] img_inst(input logic [31:0] a);
    logic [15:0] lo;
    lo = img_hw(a);
    if (lo[1:0] == 2'b11) return {img_hw(a + 32'd2), lo};
    return {16'h0000, lo};
  endfunction

  function automatic logic [31:0] inst_len(input logic [31:0] i);
    return (i[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: request-side rules, issued-instruction scoreboard, liveness.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.fet_mem_enable) begin
        check32("req_back_to_back", 32'(men_prev), 32'h0);
        check32("req_while_busy", 32'(busy_prev), 32'h0);
        check32("req_on_flush", 32'(flush_prev), 32'h0);
        check32("req_pc", bus.fet_pc, fetch_exp_prev);
      end
      if (bus.fet_inst_valid) begin
        mon_ei = img_inst(model_pc);
        check32("issue_pc", bus.fet_inst_pc, model_pc);
        check32("issue_inst", bus.fet_inst, mon_ei);
        check32("issue_is_c", 32'(bus.fet_inst_is_c), 32'(mon_ei[1:0] != 2'b11));
      end
      if (bus.flush) begin
        if (redir_q.size() == 0) begin
          check32("redirect_queue", 32'h0, 32'h1);
        end else begin
          model_pc = redir_q.pop_front();
        end
        idle_cyc = 0;
      end else if (bus.fet_inst_valid && !bus.stall) begin
        model_pc = model_pc + inst_len(img_inst(model_pc));
        consumed++;
        idle_cyc = 0;
      end else begin
        idle_cyc++;
      end
      if (idle_cyc > 400) begin
        check32("progress_timeout", 32'(idle_cyc), 32'h0);
        idle_cyc = 0;
      end
      mon_pend = bus.fet_inst_valid && bus.stall && !bus.flush;
      fetch_exp_prev = model_pc + (mon_pend ? inst_len(img_inst(model_pc)) : 32'h0);
      men_prev   = bus.fet_mem_enable;
      busy_prev  = bus.mem_fet_busy;
      flush_prev = bus.flush;
    end
  end

  // Memory controller model: queued requests with random latency, stale
  // refills after flushes are still delivered, plus junk refills on odd addresses.
  initial begin
    logic [31:0] a;
    bit          sent;
    bus.mem_fet_busy   = 1'b0;
    bus.mem_inst_ready = 1'b0;
    bus.mem_inst       = 32'h0;
    bus.mem_inst_addr  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_inst_ready = 1'b0;
      sent = 1'b0;
      if (bus.fet_mem_enable) begin
        rq_addr.push_back(bus.fet_pc);
        rq_dly.push_back(int'($urandom_range(1, 6)));
      end
      if (rq_addr.size() != 0) begin
        rq_dly[0] = rq_dly[0] - 1;
        if (rq_dly[0] <= 0) begin
          a = rq_addr.pop_front();
          void'(rq_dly.pop_front());
          bus.mem_inst_ready = 1'b1;
          bus.mem_inst_addr  = a;
          bus.mem_inst       = img_inst(a);
          sent = 1'b1;
        end
      end
      if (!sent && junk_en && ($urandom % 12 == 0)) begin
        a = $urandom;
        a[0] = 1'b1;
        bus.mem_inst_ready = 1'b1;
        bus.mem_inst_addr  = a;
        bus.mem_inst       = 32'hDEAD_0000 | ($urandom & 32'hFFFF);
      end
      bus.mem_fet_busy = (rq_addr.size() != 0) || force_busy ||
                         (rand_busy && ($urandom % 4 == 0));
    end
  end

  task automatic do_flush(input logic [31:0] target);
    @(posedge clk);
    #1;
    bus.flush    = 1'b1;
    bus.flush_pc = target;
    redir_q.push_back(target);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  // Stimulus: reset, directed scenarios, then a randomized run.
  initial begin
    int c0;
    bit seen;
    logic [31:0] t;
    rst          = 1'b1;
    bus.rdy      = 1'b1;
    bus.flush    = 1'b0;
    bus.flush_pc = 32'h0;
    bus.stall    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_mem_enable", 32'(bus.fet_mem_enable), 32'h0);
    check32("rst_fet_pc", bus.fet_pc, 32'h0);
    check32("rst_valid", 32'(bus.fet_inst_valid), 32'h0);
    check32("rst_inst", bus.fet_inst, 32'h0);
    check32("rst_inst_pc", bus.fet_inst_pc, 32'h0);
    check32("rst_is_c", 32'(bus.fet_inst_is_c), 32'h0);

    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // cold start from 0: warm up 0, 4, 6, 8 ...
    for (int i = 0; i < 300 && consumed < 5; i++) @(posedge clk);
    check32("warmup_done", 32'(consumed >= 5), 32'h1);

    // hit loop from 0, then stall on the third issue
    do_flush(32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) bus.stall = 1'b1;
      @(negedge clk);
      check32("hitloop_valid", 32'(bus.fet_inst_valid), 32'h1);
      check32("hitloop_no_req", 32'(bus.fet_mem_enable), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check32("stall_valid", 32'(bus.fet_inst_valid), 32'h1);
      check32("stall_pc", bus.fet_inst_pc, 32'h6);
      check32("stall_no_req", 32'(bus.fet_mem_enable), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check32("release_valid", 32'(bus.fet_inst_valid), 32'h1);
    check32("release_pc", bus.fet_inst_pc, 32'h8);

    // conflict: 0x80 shares an index with 0 and evicts it
    do_flush(32'h80);
    c0 = consumed;
    for (int i = 0; i < 100 && consumed == c0; i++) @(posedge clk);
    check32("conflict_fill", 32'(consumed > c0), 32'h1);
    do_flush(32'h0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.fet_mem_enable && bus.fet_pc == 32'h0) seen = 1'b1;
    end
    check32("conflict_refetch0", 32'(seen), 32'h1);

    // busy controller holds off the request until it drops
    @(posedge clk);
    #1;
    force_busy = 1'b1;
    do_flush(32'h200);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fet_mem_enable) seen = 1'b1;
    end
    check32("busy_no_req", 32'(seen), 32'h0);
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.fet_mem_enable && bus.fet_pc == 32'h200) seen = 1'b1;
    end
    check32("busy_release_req", 32'(seen), 32'h1);

    // randomized run: stalls, flushes (including near the wrap), busy, junk refills
    c0 = consumed;
    rand_busy = 1'b1;
    junk_en   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      bus.stall = ($urandom % 4 == 0);
      bus.flush = 1'b0;
      if ($urandom % 40 == 0) begin
        if ($urandom % 8 == 0) begin
          t = 32'hFFFF_FFF0 | (($urandom % 8) << 1);
        end else begin
          t = ($urandom % 256) << 1;
        end
        bus.flush    = 1'b1;
        bus.flush_pc = t;
        redir_q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rand_busy = 1'b0;
    junk_en   = 1'b0;
    repeat (40) @(posedge clk);
    check32("random_throughput", 32'(consumed - c0 > 300), 32'h1);
    check32("redirects_all_seen", 32'(redir_q.size()), 32'h0);

    @(negedge clk);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
